// File: rtl/div_pkg.sv
// div_pkg
// Shared definitions for the divide issue/completion sequencer:
//   - div_state_t : sequencer FSM states
//   - F3_*        : accepted M-extension funct3 encodings
//   - INT_MIN / ALL_ONES : operand/result constants for the RISC-V corner cases
package div_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT,
    CAPTURE,
    DONE
  } div_state_t;

  localparam logic [2:0] F3_DIV  = 3'b100;
  localparam logic [2:0] F3_DIVU = 3'b101;
  localparam logic [2:0] F3_REM  = 3'b110;
  localparam logic [2:0] F3_REMU = 3'b111;

  localparam logic [31:0] INT_MIN  = 32'h8000_0000;
  localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

endpackage

// File: rtl/div_special_detect.sv
// div_special_detect
// Purely combinational recogniser for the divide cases that RISC-V defines
// without needing the iterative divider: divide-by-zero and signed overflow.
// Ports:
//   func3          in  3   instruction funct3 (only 1xx codes are divides)
//   rs1, rs2       in  32  dividend, divisor
//   is_special     out 1   operand pair is resolved locally
//   special_result out 32  architectural rd value for that case
module div_special_detect
  import div_pkg::*;
(
  input  logic [2:0]  func3,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  output logic        is_special,
  output logic [31:0] special_result
);

  logic is_div_op;
  logic is_rem;
  logic div_by_zero;
  logic overflow;

  // Divide-by-zero applies to all four ops; overflow only to the signed
  // pair (DIV/REM) with INT_MIN / -1. Remainders return the dividend on a
  // zero divisor and zero on overflow; quotients return all ones and
  // INT_MIN respectively.
  always_comb begin
    is_div_op      = (func3 == F3_DIV) || (func3 == F3_DIVU) ||
                     (func3 == F3_REM) || (func3 == F3_REMU);
    is_rem         = (func3 == F3_REM) || (func3 == F3_REMU);
    div_by_zero    = is_div_op && (rs2 == '0);
    overflow       = ((func3 == F3_DIV) || (func3 == F3_REM)) &&
                     (rs1 == INT_MIN) && (rs2 == ALL_ONES);
    is_special     = div_by_zero || overflow;
    special_result = '0;
    if (div_by_zero) begin
      special_result = is_rem ? rs1 : ALL_ONES;
    end else if (overflow) begin
      special_result = is_rem ? '0 : INT_MIN;
    end
  end

endmodule

// File: rtl/div_sequencer.sv
// div_sequencer
// Issue/completion sequencer in front of the M-extension divider wrapper.
// Accepts a DIV/DIVU/REM/REMU op, stalls execute, launches the divider with a
// single go pulse, holds operands stable and captures the result. Zero
// divisors and signed overflow are answered locally without a launch.
// Optional feature macro: DIV_RESULT_CACHE_EN adds a one-entry result cache
// keyed on {rs1, rs2, func3}; when undefined every normal op is launched.
// Ports:
//   clk, clr           in   clock, synchronous active-high reset
//   valid_in, func3    in   op strobe and funct3 from execute
//   rs1, rs2           in   dividend, divisor
//   rd_addr_in         in   destination register
//   stall              out  combinational hold for execute
//   div_go             out  one-cycle divider launch
//   div_func3          out  func3[1:0] to divider
//   div_rs1, div_rs2   out  operands to divider, held LAUNCH..CAPTURE
//   div_done, div_rd   in   divider completion and result
//   result_valid       out  one-cycle result strobe
//   result             out  final rd value
//   rd_addr_out        out  destination for result
//   timeout_err        out  one-cycle pulse when the divider never answered
module div_sequencer
  import div_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        valid_in,
  input  logic [2:0]  func3,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic [4:0]  rd_addr_in,
  output logic        stall,
  output logic        div_go,
  output logic [1:0]  div_func3,
  output logic [31:0] div_rs1,
  output logic [31:0] div_rs2,
  input  logic        div_done,
  input  logic [31:0] div_rd,
  output logic        result_valid,
  output logic [31:0] result,
  output logic [4:0]  rd_addr_out,
  output logic        timeout_err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  div_state_t    state;
  logic [CW-1:0] wait_cnt;
  logic          accept;
  logic          is_special;
  logic [31:0]   special_result;
  logic          cache_hit;
  logic [31:0]   cache_result;

  div_special_detect u_special (
    .func3          (func3),
    .rs1            (rs1),
    .rs2            (rs2),
    .is_special     (is_special),
    .special_result (special_result)
  );

  // An op is only taken while idle; non-divide funct3 codes are ignored.
  assign accept = (state == IDLE) && valid_in && func3[2];

  // Execute is held for the whole divider round trip, including the accept
  // cycle itself, unless the op can be answered locally next cycle.
  assign stall = (state == LAUNCH) || (state == WAIT) || (state == CAPTURE) ||
                 (accept && !is_special && !cache_hit);

`ifdef DIV_RESULT_CACHE_EN
  logic        cache_valid;
  logic [31:0] cache_rs1;
  logic [31:0] cache_rs2;
  logic [1:0]  cache_func3;
  logic [31:0] cache_data;

  // Hit requires the full key; func3[2] is implied by accept.
  assign cache_hit    = cache_valid && (cache_rs1 == rs1) && (cache_rs2 == rs2) &&
                        (cache_func3 == func3[1:0]);
  assign cache_result = cache_data;

  // Only a genuine divider completion fills the cache. The held operand
  // registers are still the launched values in CAPTURE, so they form the key.
  always_ff @(posedge clk) begin
    if (clr) begin
      cache_valid <= 1'b0;
      cache_rs1   <= '0;
      cache_rs2   <= '0;
      cache_func3 <= '0;
      cache_data  <= '0;
    end else if (state == CAPTURE) begin
      cache_valid <= 1'b1;
      cache_rs1   <= div_rs1;
      cache_rs2   <= div_rs2;
      cache_func3 <= div_func3;
      cache_data  <= div_rd;
    end
  end
`else
  assign cache_hit    = 1'b0;
  assign cache_result = '0;
`endif

  // Main sequencer. Strobes default low every cycle so each is a single
  // pulse. Operand registers are only written on a normal-path accept, which
  // keeps them stable from LAUNCH through CAPTURE. In WAIT a done beats a
  // timeout falling in the same cycle.
  always_ff @(posedge clk) begin
    if (clr) begin
      state        <= IDLE;
      wait_cnt     <= '0;
      div_go       <= 1'b0;
      div_func3    <= '0;
      div_rs1      <= '0;
      div_rs2      <= '0;
      result_valid <= 1'b0;
      result       <= '0;
      rd_addr_out  <= '0;
      timeout_err  <= 1'b0;
    end else begin
      div_go       <= 1'b0;
      result_valid <= 1'b0;
      timeout_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            rd_addr_out <= rd_addr_in;
            if (is_special) begin
              result       <= special_result;
              result_valid <= 1'b1;
              state        <= DONE;
            end else if (cache_hit) begin
              result       <= cache_result;
              result_valid <= 1'b1;
              state        <= DONE;
            end else begin
              div_rs1   <= rs1;
              div_rs2   <= rs2;
              div_func3 <= func3[1:0];
              div_go    <= 1'b1;
              state     <= LAUNCH;
            end
          end
        end
        LAUNCH: begin
          wait_cnt <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          wait_cnt <= wait_cnt + 1'b1;
          if (div_done) begin
            state <= CAPTURE;
          end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
            result       <= '0;
            result_valid <= 1'b1;
            timeout_err  <= 1'b1;
            state        <= DONE;
          end
        end
        CAPTURE: begin
          result       <= div_rd;
          result_valid <= 1'b1;
          state        <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/div_sequencer.md
# div_sequencer

Issue/completion sequencer directly upstream of the M-extension divider wrapper. Accepts a decoded DIV/DIVU/REM/REMU op from execute, stalls the pipeline, launches the divider with a single `go` pulse, holds its operands stable, and captures its result. RISC-V divide-by-zero and signed-overflow cases are resolved locally without launching the divider. The block is the only driver of the divider wrapper's `go`, `func3`, `rs1` and `rs2` inputs.

## Interface
- `TIMEOUT`, 64: maximum cycles to wait for `div_done` after launch before aborting.
- `clk`  in  1  rising-edge clock, shared with the divider.
- `clr`  in  1  synchronous active-high reset, shared with the divider.
- `valid_in`  in  1  op present from execute.
- `func3`  in  3  instruction funct3; only `1xx` is accepted (100 DIV, 101 DIVU, 110 REM, 111 REMU).
- `rs1`, `rs2`  in  32  dividend, divisor.
- `rd_addr_in`  in  5  destination register.
- `stall`  out  1  combinational; holds execute.
- `div_go`  out  1  one-cycle launch pulse to the divider.
- `div_func3`  out  2  `func3[1:0]`, registered.
- `div_rs1`, `div_rs2`  out  32  registered operands.
- `div_done`  in  1  divider completion.
- `div_rd`  in  32  divider result.
- `result_valid`  out  1  one-cycle pulse.
- `result`  out  32  final rd value.
- `rd_addr_out`  out  5  destination for `result`.
- `timeout_err`  out  1  one-cycle pulse on abort.

## Operation
- Accept condition: `valid_in && func3[2]` in IDLE. Other `valid_in` values are ignored.
- Special cases are resolved at accept and go to DONE with no launch:
  - `rs2==0`: DIV/DIVU give 0xFFFFFFFF; REM/REMU give `rs1`.
  - DIV with `rs1==0x80000000, rs2==0xFFFFFFFF` gives 0x80000000; REM with the same operands gives 0.
- Normal path: latch operands, `func3[1:0]` and `rd_addr`, then go IDLE → LAUNCH → WAIT → CAPTURE → DONE.
  - LAUNCH: `div_go`=1 for exactly one cycle.
  - WAIT: poll `div_done`.
  - CAPTURE: register `div_rd` unmodified into `result`.
  - DONE: `result_valid`=1, then return to IDLE.
- `div_rs1`, `div_rs2` and `div_func3` are held constant from LAUNCH through CAPTURE inclusive.
- Wait counter: cleared in LAUNCH, incremented in WAIT. If it reaches `TIMEOUT` without `div_done`, go to DONE with `result`=0 and `timeout_err`=1 in that DONE cycle.
- `stall` = (state in LAUNCH/WAIT/CAPTURE) or (IDLE and accept and not special and not cache hit). `stall` is 0 in DONE.
- `valid_in` while not IDLE is ignored; upstream holds because `stall` is high.
- `div_done` outside WAIT is ignored.

## Timing
- Reset values: state IDLE, `stall`=0, `div_go`=0, `result_valid`=0, `timeout_err`=0, `result`=0, `rd_addr_out`=0, `div_*` operands 0, cache invalid.
- Special case or cache hit: accept in cycle T, `result_valid` in T+1, `stall` never asserted.
- Normal path:
  - accept T, `div_go` T+1.
  - `div_done` first seen at cycle D (D ≥ T+2) is sampled in WAIT.
  - CAPTURE at D+1, `result_valid` at D+2.
- `clr` mid-operation: next cycle IDLE with all outputs at reset values. No `result_valid` is produced for the aborted op and the cache is invalidated.
- `clr` and `valid_in` in the same cycle: `clr` wins and the op is dropped.
- `div_done` in the same cycle the counter reaches `TIMEOUT`: `div_done` wins and there is no error.

## Configuration
- `DIV_RESULT_CACHE_EN` defined: a one-entry cache stores {rs1, rs2, func3, result} from the last normal-path completion.
  - An accept matching all three of rs1, rs2 and func3 is a hit.
  - A hit gives `result_valid` next cycle with no launch.
  - Special cases, timeouts and `clr` never fill the cache; `clr` invalidates it.
- `DIV_RESULT_CACHE_EN` undefined: no cache storage, and every non-special op launches the divider.

## Structure
- Package `div_pkg`:
  - state enum (IDLE, LAUNCH, WAIT, CAPTURE, DONE);
  - funct3 localparams `F3_DIV`, `F3_DIVU`, `F3_REM`, `F3_REMU`;
  - constants `INT_MIN`=0x80000000 and `ALL_ONES`=0xFFFFFFFF.
- Sub-module `div_special_detect`: combinational. Takes func3, rs1, rs2 and produces `is_special` and `special_result`.

## Test plan
- DIV rs1=100, rs2=7, divider model `div_done` 10 cycles after go → one `div_go`, operands stable until CAPTURE, `result`=14 at D+2, correct `rd_addr_out`.
- REMU rs1=0x1234, rs2=0 → no `div_go`, no `stall`, `result`=0x1234 next cycle. DIVU rs1=5, rs2=0 → `result`=0xFFFFFFFF next cycle.
- DIV rs1=0x80000000, rs2=0xFFFFFFFF → `result`=0x80000000. REM with the same operands → `result`=0. No launch in either case.
- Divider never asserts done with `TIMEOUT`=64 → `timeout_err` pulse and `result`=0 on wait cycle 64, then IDLE.
- `clr` asserted in WAIT → next cycle `stall`=0 and IDLE. A late `div_done` afterwards produces no `result_valid`.
- With `DIV_RESULT_CACHE_EN`: DIVU 50/5 twice back-to-back → first via the divider, second `result_valid` next cycle with `result`=10 and no `div_go`.
